// File: rtl/time_set_ctrl.sv
// time_set_ctrl: set-time editor for a 24 h clock; pauses the counters, edits H/M/S, commits with a load strobe.
// Build macro CLOCK_SET_DOWN_EN adds btn_down decrement of the selected field.
module time_set_ctrl #(
    parameter int P_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec_tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    output logic       run_en,
    output logic       load,
    output logic [4:0] hour_set,
    output logic [5:0] min_set,
    output logic [5:0] sec_set,
    output logic [1:0] sel_field,
    output logic       blink
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        SET_SEC  = 3'd3,
        COMMIT   = 3'd4
    } state_t;

    // The abort fires on the tick that would make the counter reach P_TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(P_TIMEOUT - 1);

    state_t     state_r;
    logic       run_en_r;
    logic       load_r;
    logic       blink_r;
    logic [1:0] sel_r;
    logic [7:0] tmo_r;
    logic [4:0] hour_r;
    logic [5:0] min_r;
    logic [5:0] sec_r;
    logic [5:0] hour_step_s;
    logic [5:0] min_step_s;
    logic [5:0] sec_step_s;
    logic       down_s;

    // Out-of-range values snap to 0 rather than being corrected at capture.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
        logic [5:0] r;
        if (v >= max_v) begin
            r = 6'd0;
        end else begin
            r = v + 6'd1;
        end
        return r;
    endfunction

`ifdef CLOCK_SET_DOWN_EN
    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max_v);
        logic [5:0] r;
        if (v == 6'd0) begin
            r = max_v;
        end else begin
            r = v - 6'd1;
        end
        return r;
    endfunction

    assign down_s = btn_down;

    // Next value of each edit field: up wins over down.
    always_comb begin
        if (btn_up) begin
            hour_step_s = wrap_inc({1'b0, hour_r}, 6'd23);
            min_step_s  = wrap_inc(min_r, 6'd59);
            sec_step_s  = wrap_inc(sec_r, 6'd59);
        end else begin
            hour_step_s = wrap_dec({1'b0, hour_r}, 6'd23);
            min_step_s  = wrap_dec(min_r, 6'd59);
            sec_step_s  = wrap_dec(sec_r, 6'd59);
        end
    end
`else
    logic unused_btn_down_s;
    assign unused_btn_down_s = btn_down;
    assign down_s            = 1'b0;

    // Next value of each edit field on btn_up.
    always_comb begin
        hour_step_s = wrap_inc({1'b0, hour_r}, 6'd23);
        min_step_s  = wrap_inc(min_r, 6'd59);
        sec_step_s  = wrap_inc(sec_r, 6'd59);
    end
`endif

    // Edit FSM with registered outputs, edit registers and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= RUN;
            run_en_r <= 1'b1;
            load_r   <= 1'b0;
            blink_r  <= 1'b0;
            sel_r    <= 2'd0;
            tmo_r    <= 8'd0;
            hour_r   <= 5'd0;
            min_r    <= 6'd0;
            sec_r    <= 6'd0;
        end else begin
            case (state_r)
                RUN: begin
                    load_r  <= 1'b0;
                    blink_r <= 1'b0;
                    tmo_r   <= 8'd0;
                    if (btn_mode) begin
                        state_r  <= SET_HOUR;
                        run_en_r <= 1'b0;
                        sel_r    <= 2'd1;
                        hour_r   <= hour_in;
                        min_r    <= min_in;
                        sec_r    <= sec_in;
                    end else begin
                        state_r  <= RUN;
                        run_en_r <= 1'b1;
                        sel_r    <= 2'd0;
                    end
                end
                SET_HOUR, SET_MIN, SET_SEC: begin
                    load_r <= 1'b0;
                    if (btn_mode) begin
                        tmo_r <= 8'd0;
                        case (state_r)
                            SET_HOUR: begin
                                state_r <= SET_MIN;
                                sel_r   <= 2'd2;
                                blink_r <= blink_r ^ one_sec_tick;
                            end
                            SET_MIN: begin
                                state_r <= SET_SEC;
                                sel_r   <= 2'd3;
                                blink_r <= blink_r ^ one_sec_tick;
                            end
                            default: begin
                                state_r <= COMMIT;
                                load_r  <= 1'b1;
                                sel_r   <= 2'd0;
                                blink_r <= 1'b0;
                            end
                        endcase
                    end else if (btn_up || down_s) begin
                        tmo_r   <= 8'd0;
                        blink_r <= blink_r ^ one_sec_tick;
                        case (state_r)
                            SET_HOUR: hour_r <= hour_step_s[4:0];
                            SET_MIN:  min_r  <= min_step_s;
                            default:  sec_r  <= sec_step_s;
                        endcase
                    end else if (one_sec_tick) begin
                        if (tmo_r == TMO_LAST) begin
                            state_r  <= RUN;
                            run_en_r <= 1'b1;
                            sel_r    <= 2'd0;
                            blink_r  <= 1'b0;
                            tmo_r    <= 8'd0;
                        end else begin
                            tmo_r   <= tmo_r + 8'd1;
                            blink_r <= ~blink_r;
                        end
                    end else begin
                        tmo_r <= tmo_r;
                    end
                end
                COMMIT: begin
                    state_r  <= RUN;
                    run_en_r <= 1'b1;
                    load_r   <= 1'b0;
                    sel_r    <= 2'd0;
                    blink_r  <= 1'b0;
                    tmo_r    <= 8'd0;
                end
                default: begin
                    state_r  <= RUN;
                    run_en_r <= 1'b1;
                    load_r   <= 1'b0;
                    sel_r    <= 2'd0;
                    blink_r  <= 1'b0;
                    tmo_r    <= 8'd0;
                end
            endcase
        end
    end

    assign run_en    = run_en_r;
    assign load      = load_r;
    assign blink     = blink_r;
    assign sel_field = sel_r;
    assign hour_set  = hour_r;
    assign min_set   = min_r;
    assign sec_set   = sec_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: vector table, hand-written corner sequences, then random stimulus vs. a reference model.
module tb_time_set_ctrl;

    localparam int P_TIMEOUT = 16;
`ifdef CLOCK_SET_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
    localparam int EXP_DH  = 23;
    localparam int EXP_UH  = 0;
`else
    localparam bit DOWN_EN = 1'b0;
    localparam int EXP_DH  = 0;
    localparam int EXP_UH  = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_sec_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [4:0] hour_in = 5'd0;
    logic [5:0] min_in = 6'd0;
    logic [5:0] sec_in = 6'd0;
    logic       run_en;
    logic       load;
    logic [4:0] hour_set;
    logic [5:0] min_set;
    logic [5:0] sec_set;
    logic [1:0] sel_field;
    logic       blink;

    time_set_ctrl #(.P_TIMEOUT(P_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .one_sec_tick(one_sec_tick),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
        .run_en(run_en), .load(load), .hour_set(hour_set), .min_set(min_set),
        .sec_set(sec_set), .sel_field(sel_field), .blink(blink)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 = running, 1..3 = editing hour/min/sec, 4 = commit.
    int m_mode = 0;
    int m_h = 0, m_m = 0, m_s = 0;
    int m_idle_ticks = 0;
    int m_blink = 0;

    typedef struct {
        logic r, t, bm, bu, bd;
        int   hi, mi, si;
        int   e_run, e_load, e_sel, e_h, e_m, e_s;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int step_field(input int v, input int n, input int dir);
        if (dir > 0) return (v > n - 1) ? 0 : (v + 1) % n;
        return (v == 0) ? n - 1 : v - 1;
    endfunction

    task automatic model_step(input logic r, t, bm, bu, bd, input int hi, mi, si);
        int prev;
        prev = m_mode;
        if (r) begin
            m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_idle_ticks = 0; m_blink = 0;
        end else if (prev == 0) begin
            if (bm) begin
                m_mode = 1; m_h = hi; m_m = mi; m_s = si; m_idle_ticks = 0; m_blink = 0;
            end
        end else if (prev == 4) begin
            m_mode = 0; m_idle_ticks = 0;
        end else begin
            if (bm) begin
                m_mode = prev + 1; m_idle_ticks = 0;
            end else if (bu || (DOWN_EN && bd)) begin
                if (prev == 1) m_h = step_field(m_h, 24, bu ? 1 : -1);
                else if (prev == 2) m_m = step_field(m_m, 60, bu ? 1 : -1);
                else m_s = step_field(m_s, 60, bu ? 1 : -1);
                m_idle_ticks = 0;
            end else if (t) begin
                m_idle_ticks++;
                if (m_idle_ticks >= P_TIMEOUT) begin
                    m_mode = 0; m_idle_ticks = 0;
                end
            end
            if (t && m_mode >= 1 && m_mode <= 3) m_blink = 1 - m_blink;
        end
        if (m_mode == 0 || m_mode == 4) m_blink = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".run_en"}, int'(run_en), (m_mode == 0) ? 1 : 0);
        chk({tag, ".load"}, int'(load), (m_mode == 4) ? 1 : 0);
        chk({tag, ".sel_field"}, int'(sel_field), (m_mode >= 1 && m_mode <= 3) ? m_mode : 0);
        chk({tag, ".hour_set"}, int'(hour_set), m_h);
        chk({tag, ".min_set"}, int'(min_set), m_m);
        chk({tag, ".sec_set"}, int'(sec_set), m_s);
        chk({tag, ".blink"}, int'(blink), m_blink);
    endtask

    task automatic cycle(input logic r, t, bm, bu, bd, input int hi, mi, si, input string tag);
        reset = r; one_sec_tick = t; btn_mode = bm; btn_up = bu; btn_down = bd;
        hour_in = 5'(hi); min_in = 6'(mi); sec_in = 6'(si);
        @(posedge clk);
        model_step(r, t, bm, bu, bd, hi, mi, si);
        #1;
        check_model(tag);
    endtask

    function automatic void add(input logic r, t, bm, bu, bd, input int hi, mi, si,
                                input int er, el, es, eh, em, esec);
        vec_t v;
        v.r = r; v.t = t; v.bm = bm; v.bu = bu; v.bd = bd;
        v.hi = hi; v.mi = mi; v.si = si;
        v.e_run = er; v.e_load = el; v.e_sel = es; v.e_h = eh; v.e_m = em; v.e_s = esec;
        vecs.push_back(v);
    endfunction

    initial begin
        // reset, then idle ticks
        add(1, 0, 0, 0, 0, 23, 59, 58,  1, 0, 0,  0,  0,  0);
        add(0, 1, 0, 0, 0, 23, 59, 58,  1, 0, 0,  0,  0,  0);
        add(0, 1, 0, 0, 0, 23, 59, 58,  1, 0, 0,  0,  0,  0);
        add(0, 1, 0, 0, 0, 23, 59, 58,  1, 0, 0,  0,  0,  0);
        // capture 23:59:58, wrap hour, bump minutes twice, commit
        add(0, 0, 1, 0, 0, 23, 59, 58,  0, 0, 1, 23, 59, 58);
        add(0, 0, 0, 1, 0, 23, 59, 58,  0, 0, 1,  0, 59, 58);
        add(0, 0, 1, 0, 0, 23, 59, 58,  0, 0, 2,  0, 59, 58);
        add(0, 0, 0, 1, 0, 23, 59, 58,  0, 0, 2,  0,  0, 58);
        add(0, 0, 0, 1, 0, 23, 59, 58,  0, 0, 2,  0,  1, 58);
        add(0, 0, 1, 0, 0, 23, 59, 58,  0, 0, 3,  0,  1, 58);
        add(0, 0, 1, 0, 0, 23, 59, 58,  0, 1, 0,  0,  1, 58);
        add(0, 0, 0, 0, 0, 23, 59, 58,  1, 0, 0,  0,  1, 58);
        // mode beats up in the same cycle; buttons in COMMIT ignored
        add(0, 0, 1, 0, 0, 23, 59, 58,  0, 0, 1, 23, 59, 58);
        add(0, 0, 1, 0, 0, 23, 59, 58,  0, 0, 2, 23, 59, 58);
        add(0, 0, 1, 1, 0, 23, 59, 58,  0, 0, 3, 23, 59, 58);
        add(0, 0, 1, 1, 1, 23, 59, 58,  0, 1, 0, 23, 59, 58);
        add(0, 0, 1, 1, 1, 23, 59, 58,  1, 0, 0, 23, 59, 58);
        add(0, 0, 0, 0, 0, 23, 59, 58,  1, 0, 0, 23, 59, 58);
        // btn_down at hour 0
        add(0, 0, 1, 0, 0,  0,  5,  7,  0, 0, 1,  0,  5,  7);
        add(0, 0, 0, 0, 1,  0,  5,  7,  0, 0, 1, EXP_DH, 5, 7);
        add(0, 0, 0, 1, 0,  0,  5,  7,  0, 0, 1, EXP_UH, 5, 7);
        // out-of-range captures wrap to 0 on the next increment
        add(1, 0, 0, 0, 0, 25, 60, 63,  1, 0, 0,  0,  0,  0);
        add(0, 0, 1, 0, 0, 25, 60, 63,  0, 0, 1, 25, 60, 63);
        add(0, 0, 0, 1, 0, 25, 60, 63,  0, 0, 1,  0, 60, 63);
        add(0, 0, 1, 0, 0, 25, 60, 63,  0, 0, 2,  0, 60, 63);
        add(0, 0, 0, 1, 0, 25, 60, 63,  0, 0, 2,  0,  0, 63);

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].t, vecs[i].bm, vecs[i].bu, vecs[i].bd,
                  vecs[i].hi, vecs[i].mi, vecs[i].si, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_run_en", i), int'(run_en), vecs[i].e_run);
            chk($sformatf("vec%0d.tbl_load", i), int'(load), vecs[i].e_load);
            chk($sformatf("vec%0d.tbl_sel", i), int'(sel_field), vecs[i].e_sel);
            chk($sformatf("vec%0d.tbl_hour", i), int'(hour_set), vecs[i].e_h);
            chk($sformatf("vec%0d.tbl_min", i), int'(min_set), vecs[i].e_m);
            chk($sformatf("vec%0d.tbl_sec", i), int'(sec_set), vecs[i].e_s);
        end

        // Timeout in SET_SEC: 16 ticks without buttons aborts with no load
        cycle(0, 0, 1, 0, 0, 0, 0, 0, "to_enter");
        chk("to_enter.sel", int'(sel_field), 3);
        for (int k = 1; k <= 16; k++) begin
            cycle(0, 1, 0, 0, 0, 0, 0, 0, $sformatf("to_tick%0d", k));
            chk($sformatf("to_tick%0d.sel", k), int'(sel_field), (k < 16) ? 3 : 0);
            chk($sformatf("to_tick%0d.run_en", k), int'(run_en), (k < 16) ? 0 : 1);
            chk($sformatf("to_tick%0d.load", k), int'(load), 0);
            for (int j = 0; j < 2; j++) begin
                cycle(0, 0, 0, 0, 0, 0, 0, 0, "to_idle");
                chk("to_idle.load", int'(load), 0);
            end
        end
        chk("to_done.sec_set", int'(sec_set), 63);

        // Blink: cleared on entry, toggles per tick, also alongside a button press
        cycle(0, 1, 1, 0, 0, 4, 5, 6, "bl_enter");
        chk("bl_enter.blink", int'(blink), 0);
        cycle(0, 1, 0, 0, 0, 4, 5, 6, "bl_t1");
        chk("bl_t1.blink", int'(blink), 1);
        cycle(0, 1, 0, 0, 0, 4, 5, 6, "bl_t2");
        chk("bl_t2.blink", int'(blink), 0);
        cycle(0, 1, 0, 1, 0, 4, 5, 6, "bl_up");
        chk("bl_up.blink", int'(blink), 1);
        chk("bl_up.hour_set", int'(hour_set), 5);
        cycle(0, 0, 1, 0, 0, 4, 5, 6, "bl_m1");
        cycle(0, 0, 1, 0, 0, 4, 5, 6, "bl_m2");
        cycle(0, 0, 1, 0, 0, 4, 5, 6, "bl_commit");
        chk("bl_commit.blink", int'(blink), 0);
        chk("bl_commit.load", int'(load), 1);
        cycle(0, 0, 0, 0, 0, 4, 5, 6, "bl_run");

        // Reset in SET_MIN aborts with no load pulse
        cycle(0, 0, 1, 0, 0, 10, 20, 30, "rs_enter");
        cycle(0, 0, 1, 0, 0, 10, 20, 30, "rs_min");
        cycle(0, 0, 0, 1, 0, 10, 20, 30, "rs_up");
        chk("rs_up.min_set", int'(min_set), 21);
        cycle(1, 0, 1, 0, 0, 10, 20, 30, "rs_reset");
        chk("rs_reset.load", int'(load), 0);
        chk("rs_reset.run_en", int'(run_en), 1);
        chk("rs_reset.sel", int'(sel_field), 0);
        chk("rs_reset.sets", int'(hour_set) + int'(min_set) + int'(sec_set), 0);
        cycle(0, 0, 0, 0, 0, 10, 20, 30, "rs_after");
        chk("rs_after.load", int'(load), 0);

        // Random stimulus, alternating busy and button-quiet phases
        for (int i = 0; i < 4000; i++) begin
            logic quiet, r, t, bm, bu, bd;
            quiet = ((i / 300) % 2) == 1;
            r  = ($urandom_range(0, 499) == 0);
            t  = ($urandom_range(0, 3) == 0);
            bm = quiet ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) == 0);
            bu = quiet ? 1'b0 : ($urandom_range(0, 4) == 0);
            bd = quiet ? 1'b0 : ($urandom_range(0, 4) == 0);
            cycle(r, t, bm, bu, bd, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 63)), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter P_TIMEOUT, 16, number of one_sec_tick pulses without a button press before edit mode aborts; legal range 2..255.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 one_sec_tick  input  1  single-cycle 1 Hz strobe.
REQ-005 btn_mode  input  1  debounced single-cycle pulse; advances edit field.
REQ-006 btn_up  input  1  debounced single-cycle pulse; increments selected field.
REQ-007 btn_down  input  1  debounced single-cycle pulse; decrements selected field (see Configuration).
REQ-008 hour_in / min_in / sec_in  input  5 / 6 / 6  live counter values, binary, 0..23 / 0..59 / 0..59.
REQ-009 run_en  output  1  enable for the seconds/minutes/hours counters; high only in RUN.
REQ-010 load  output  1  single-cycle strobe; counters load hour_set/min_set/sec_set.
REQ-011 hour_set / min_set / sec_set  output  5 / 6 / 6  edit registers, driven continuously.
REQ-012 sel_field  output  2  0 = none (RUN), 1 = hour, 2 = minute, 3 = second.
REQ-013 blink  output  1  display blanking phase for the selected field.

Function
REQ-014 FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT; all outputs are registered or decoded from the state register only.
REQ-015 RUN + btn_mode -> SET_HOUR next cycle; same edge captures hour_in/min_in/sec_in into the edit registers.
REQ-016 SET_HOUR + btn_mode -> SET_MIN; SET_MIN + btn_mode -> SET_SEC; SET_SEC + btn_mode -> COMMIT.
REQ-017 COMMIT lasts exactly one cycle: load=1, run_en=0, then -> RUN unconditionally; buttons in COMMIT are ignored.
REQ-018 run_en=1 in RUN only; run_en falls in the cycle after btn_mode in RUN; it rises the cycle after COMMIT.
REQ-019 btn_up in a SET state increments the selected edit register by 1 next cycle; hour wraps 23->0, minute and second wrap 59->0.
REQ-020 Unselected edit registers hold; btn_up/btn_down in RUN are ignored.
REQ-021 Priority on the same cycle: btn_mode > btn_up > btn_down; the lower-priority pulses are dropped, not queued.
REQ-022 Timeout counter (8 bit) clears on any button pulse and on every state change; it increments on one_sec_tick in SET states.
REQ-023 Counter reaching P_TIMEOUT in a SET state -> RUN next cycle with load=0 (abort); edit registers keep their values.
REQ-024 blink toggles on each one_sec_tick in SET states; it is forced 0 in RUN/COMMIT and on entry to SET_HOUR.
REQ-025 Out-of-range captured values (e.g. hour_in=25) are not corrected at capture; the next increment yields 0.

Reset
REQ-026 reset has priority over all inputs: state=RUN, run_en=1, load=0, edit registers=0, sel_field=0, blink=0, timeout counter=0.
REQ-027 reset asserted mid-edit or in COMMIT aborts with no load pulse in the reset cycle or after it.

Configuration
REQ-028 Macro CLOCK_SET_DOWN_EN defined: btn_down decrements the selected field, hour 0->23, minute and second 0->59; it also clears the timeout counter.
REQ-029 CLOCK_SET_DOWN_EN undefined: btn_down is ignored entirely; no decrement logic is synthesized and the timeout counter is unaffected by it.

Verification
REQ-030 Reset, then idle 3 ticks -> run_en=1, load=0, sel_field=0, all *_set=0.
REQ-031 In RUN with hour_in=23, min_in=59, sec_in=58: btn_mode, then btn_up -> hour_set=0; mode, 2x up -> min_set=1; mode, mode -> one-cycle load with 0/1/58, then run_en=1.
REQ-032 In SET_MIN with min_set=59: btn_mode and btn_up in the same cycle -> SET_SEC, min_set stays 59.
REQ-033 In SET_SEC, no buttons for 16 ticks -> RUN on the cycle after the 16th tick, load never asserted, run_en=1.
REQ-034 With CLOCK_SET_DOWN_EN defined: in SET_HOUR with hour_set=0, btn_down -> hour_set=23. Without the macro: same stimulus -> hour_set=0.
REQ-035 Assert reset in SET_MIN, one cycle before the COMMIT path -> no load pulse, state RUN, all *_set=0.
